ps2_line_debouncer: RTL and testbench
=====================================

Name: ps2_line_debouncer

Overview:
Two-channel synchronizer/debouncer for the PS/2 keyboard clock and data lines, placed between the raw pins and the keyboard Wishbone peripheral's bit-capture logic. Each channel passes its asynchronous input through a 2-flop synchronizer. The registered output changes only after the synchronized input has held a new level for STABLE_CYCLES consecutive clocks. The channels are identical and fully independent.

Parameters:
STABLE_CYCLES, 19, consecutive cycles a synchronized input must differ from its output before the output adopts it; legal range >= 1.
CNT_WIDTH, $clog2(STABLE_CYCLES+1), width of each per-channel counter; derived, do not override.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset, synchronous, active-high.
I0  input  1  raw PS/2 clock line, asynchronous.
I1  input  1  raw PS/2 data line, asynchronous.
O0  output  1  debounced I0, registered.
O1  output  1  debounced I1, registered.

Behaviour:
- Reset: one clock, one reset, synchronous, active-high (rst sampled on rising clk). While rst=1 at an edge:
  - sync flops set to 1
  - counters set to 0
  - O0 and O1 set to 1 (PS/2 idle-high)
- Per channel n, every rising edge with rst=0:
  - Synchronizer: sa<=In; sb<=sa. Only sb is used downstream.
  - If sb==On: cnt<=0.
  - Else if cnt==STABLE_CYCLES-1: On<=sb, cnt<=0.
  - Else: cnt<=cnt+1.
- Latency:
  - An input level change first sampled at edge k, then held, appears on On at edge k+STABLE_CYCLES+1.
  - That is the (STABLE_CYCLES+2)th edge counting k as the first; 21 edges at default.
- Glitch rejection: a synchronized deviation lasting fewer than STABLE_CYCLES cycles resets the counter on return and never reaches On.
- A bounce mid-count restarts the count from 0; there is no accumulation across bounces.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around.
- STABLE_CYCLES=1: On follows sb with one cycle delay.
- Simultaneous changes on I0 and I1 are handled independently, with identical latency.
- Reset mid-count: counter is discarded and outputs return to 1 the cycle after rst.
- No combinational path from any input to any output.

Optional Feature:
Macro DEBOUNCER_FALL_PULSE_EN.
- Defined: adds output port O0_fall (1 bit, registered, reset 0).
  - O0_fall=1 for exactly one cycle: the first cycle in which O0 reads 0 after having read 1.
  - Otherwise O0_fall=0.
  - Gives downstream capture a clean sampling strobe without a derived clock.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset: hold I0=I1=0, assert rst 3 cycles -> O0=O1=1 the edge after rst; after release, O0 goes 0 at the 21st edge (STABLE_CYCLES=19).
2. Clean transition: from idle, drive I1 1->0 and hold -> O1 stays 1 for 20 edges and goes 0 at edge 21; O0 unchanged at 1.
3. Glitch: pulse I0 low for 10 cycles -> O0 remains 1 throughout. Pulse I0 low for 19 cycles (aligned to edges) -> O0 goes low for exactly 19 cycles, delayed by 21 edges.
4. Bounce: I0 low 12 cycles, high 2, low held -> O0 falls 21 edges after the final falling transition, not the first.
5. Mid-count reset: I1 low 15 cycles, then rst 1 cycle, I1 held low -> O1=1 after reset; falls 21 edges after rst deasserts.
6. With DEBOUNCER_FALL_PULSE_EN: PS/2 frame of 11 clock pulses (40 us low/high at 50 MHz) on I0 -> O0_fall yields exactly 11 single-cycle pulses, each coincident with O0's first low cycle.

Source files
------------

// File: rtl/ps2_line_debouncer.sv
// Two-channel PS/2 clock/data synchronizer and debouncer; outputs idle high.
// Optional DEBOUNCER_FALL_PULSE_EN adds O0_fall, a one-cycle strobe on O0 falling.
module ps2_line_debouncer #(
  parameter int STABLE_CYCLES = 19,
  parameter int CNT_WIDTH     = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic I0,
  input  logic I1,
  output logic O0,
  output logic O1
`ifdef DEBOUNCER_FALL_PULSE_EN
  ,
  output logic O0_fall
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [1:0]           pin_w;
  logic [1:0]           sa_q;
  logic [1:0]           sb_q;
  logic [1:0]           out_q;
  logic [1:0]           out_d;
  logic [CNT_WIDTH-1:0] cnt_q [2];
  logic [CNT_WIDTH-1:0] cnt_d [2];

  assign pin_w = {I1, I0};

  // Counter tracks how long sb has disagreed with the output; any agreement clears it.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      out_d[n] = out_q[n];
      cnt_d[n] = cnt_q[n];
      if (sb_q[n] == out_q[n]) begin
        cnt_d[n] = '0;
      end else if (cnt_q[n] == CNT_LAST) begin
        out_d[n] = sb_q[n];
        cnt_d[n] = '0;
      end else begin
        cnt_d[n] = cnt_q[n] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q     <= 2'b11;
      sb_q     <= 2'b11;
      out_q    <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sa_q     <= pin_w;
      sb_q     <= sa_q;
      out_q    <= out_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign O0 = out_q[0];
  assign O1 = out_q[1];

`ifdef DEBOUNCER_FALL_PULSE_EN
  logic fall_q;
  logic fall_d;

  // Registered alongside O0 so the strobe lands on O0's first low cycle.
  assign fall_d = out_q[0] & ~out_d[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= fall_d;
    end
  end

  assign O0_fall = fall_q;
`endif

endmodule

// File: tb/tb_ps2_line_debouncer.sv
// Directed bench for ps2_line_debouncer at STABLE_CYCLES=19 (21-edge latency).
// Build with DEBOUNCER_FALL_PULSE_EN to also exercise O0_fall.
module tb_ps2_line_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic I0;
  logic I1;
  logic O0;
  logic O1;
`ifdef DEBOUNCER_FALL_PULSE_EN
  logic O0_fall;
`endif

  int checks = 0;
  int errors = 0;

  ps2_line_debouncer #(.STABLE_CYCLES(19)) dut (
    .clk (clk),
    .rst (rst),
    .I0  (I0),
    .I1  (I1),
    .O0  (O0),
    .O1  (O1)
`ifdef DEBOUNCER_FALL_PULSE_EN
    ,
    .O0_fall (O0_fall)
`endif
  );

  always #5 clk = ~clk;

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  int first_low;
  int low_cnt;
  int hi_breaks;
`ifdef DEBOUNCER_FALL_PULSE_EN
  int   pulses;
  int   bad_pulses;
  logic prev_o0;
`endif

  initial begin
    // 1. Reset with inputs low
    rst = 1'b1;
    I0  = 1'b0;
    I1  = 1'b0;
    tick(1);
    check("rst_O0", int'(O0), 1);
    check("rst_O1", int'(O1), 1);
    tick(2);
    rst = 1'b0;
    tick(20);
    check("rel_O0_edge20", int'(O0), 1);
    check("rel_O1_edge20", int'(O1), 1);
    tick(1);
    check("rel_O0_edge21", int'(O0), 0);
    check("rel_O1_edge21", int'(O1), 0);
    I0 = 1'b1;
    I1 = 1'b1;
    tick(25);
    check("idle_O0", int'(O0), 1);
    check("idle_O1", int'(O1), 1);

    // 2. Clean fall on I1 only
    I1 = 1'b0;
    tick(20);
    check("clean_O1_edge20", int'(O1), 1);
    tick(1);
    check("clean_O1_edge21", int'(O1), 0);
    check("clean_O0_unchanged", int'(O0), 1);
    I1 = 1'b1;
    tick(20);
    check("clean_O1_rise_edge20", int'(O1), 0);
    tick(1);
    check("clean_O1_rise_edge21", int'(O1), 1);
    tick(5);

    // 3a. 10-cycle glitch never reaches O0
    I0 = 1'b0;
    hi_breaks = 0;
    for (int t = 1; t <= 40; t++) begin
      if (t == 11) I0 = 1'b1;
      tick(1);
      if (O0 !== 1'b1) hi_breaks++;
    end
    check("glitch10_O0_low_cycles", hi_breaks, 0);

    // 3b. 19-cycle low pulse passes as 19 low cycles, 21 edges late
    I0 = 1'b0;
    first_low = 0;
    low_cnt = 0;
    for (int t = 1; t <= 50; t++) begin
      if (t == 20) I0 = 1'b1;
      tick(1);
      if (O0 === 1'b0) begin
        low_cnt++;
        if (first_low == 0) first_low = t;
      end
    end
    check("pulse19_first_low_edge", first_low, 21);
    check("pulse19_low_cycles", low_cnt, 19);
    check("pulse19_O0_end", int'(O0), 1);

    // 4. Bounce restarts the count
    I0 = 1'b0;
    tick(12);
    I0 = 1'b1;
    tick(2);
    I0 = 1'b0;
    tick(20);
    check("bounce_O0_edge20_after_final", int'(O0), 1);
    tick(1);
    check("bounce_O0_edge21_after_final", int'(O0), 0);
    I0 = 1'b1;
    tick(25);
    check("bounce_O0_restored", int'(O0), 1);

    // 5. Reset mid-count discards progress
    I1 = 1'b0;
    tick(15);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_O1", int'(O1), 1);
    check("midrst_O0", int'(O0), 1);
    tick(20);
    check("midrst_O1_edge20", int'(O1), 1);
    tick(1);
    check("midrst_O1_edge21", int'(O1), 0);
    I1 = 1'b1;
    tick(25);
    check("midrst_O1_restored", int'(O1), 1);

`ifdef DEBOUNCER_FALL_PULSE_EN
    // 6. PS/2 frame: 11 clock pulses of 2000 cycles low / 2000 high
    check("fall_idle", int'(O0_fall), 0);
    pulses = 0;
    bad_pulses = 0;
    prev_o0 = O0;
    for (int p = 0; p < 11; p++) begin
      for (int c = 0; c < 4000; c++) begin
        I0 = (c < 2000) ? 1'b0 : 1'b1;
        tick(1);
        if (O0_fall === 1'b1) pulses++;
        if ((O0_fall === 1'b1) != (prev_o0 === 1'b1 && O0 === 1'b0)) bad_pulses++;
        prev_o0 = O0;
      end
    end
    tick(30);
    if (O0_fall === 1'b1) pulses++;
    check("frame_fall_pulses", pulses, 11);
    check("frame_fall_alignment", bad_pulses, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
